// File: rtl/wb_timer_pkg.sv
// Shared constants, FSM type and the byte-lane merge helper for the
// Wishbone machine-timer responder.
package wb_timer_pkg;

    localparam logic [4:0] OFS_MTIME_LO    = 5'h00;
    localparam logic [4:0] OFS_MTIME_HI    = 5'h04;
    localparam logic [4:0] OFS_MTIMECMP_LO = 5'h08;
    localparam logic [4:0] OFS_MTIMECMP_HI = 5'h0C;
    localparam logic [4:0] OFS_CTRL        = 5'h10;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_DIV_LSB = 16;

    typedef enum logic {IDLE, RESP} state_t;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  sel);
        logic [31:0] merged;
        for (int i = 0; i < 4; i++)
            merged[8*i +: 8] = sel[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        return merged;
    endfunction

endpackage

// File: rtl/wb_timer_counter.sv
// Prescaled 64-bit mtime counter. A bus load of either half wins over an
// increment in the same cycle and restarts the prescaler.
module wb_timer_counter #(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] div,
    input  logic                  load_lo,
    input  logic                  load_hi,
    input  logic [31:0]           load_data,
    input  logic                  clr_pre,
    output logic [63:0]           mtime
);

    logic [PRESCALE_W-1:0] pre;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtime <= '0;
            pre   <= '0;
        end else if (load_lo || load_hi) begin
            pre <= '0;
            if (load_lo) mtime[31:0]  <= load_data;
            if (load_hi) mtime[63:32] <= load_data;
        end else if (clr_pre) begin
            pre <= '0;
        end else if (en) begin
            // div == 0 means one tick per cycle
            if (pre == div) begin
                pre   <= '0;
                mtime <= mtime + 64'd1;
            end else begin
                pre <= pre + 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_timer_responder.sv
// Wishbone classic responder exposing a RISC-V style machine timer
// (mtime, mtimecmp, CTRL) and a registered level timer interrupt.
module wb_timer_responder
    import wb_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0200_0000,
    parameter int          PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc,
    input  logic        wb_stb,
    input  logic        wb_we,
    input  logic [3:0]  wb_sel,
    input  logic [31:0] wb_adr,
    input  logic [31:0] wb_dat_mosi,
    output logic [31:0] wb_dat_miso,
    output logic        wb_ack,
    output logic        wb_err,
    output logic        timer_interrupt_out
);

    state_t                state, state_nxt;
    logic [63:0]           mtime, mtimecmp;
    logic                  ctrl_en;
    logic [PRESCALE_W-1:0] ctrl_div;
    logic [4:0]            ofs;
    logic                  req, hit, hit_q, wr;
    logic [31:0]           ctrl_word, rd_word, wr_val;

    assign ofs = {wb_adr[4:2], 2'b00};
    assign req = (state == IDLE) && wb_cyc && wb_stb;
    assign hit = ((wb_adr & ~32'h1F) == BASE_ADDR) && (ofs <= OFS_CTRL);
    // an all-zero byte mask is a no-op write: it must not disturb the counter
    assign wr  = req && hit && wb_we && (wb_sel != 4'b0000);

    always_comb begin
        ctrl_word = '0;
        ctrl_word[CTRL_EN_BIT] = ctrl_en;
        ctrl_word[CTRL_DIV_LSB +: PRESCALE_W] = ctrl_div;
        case (ofs)
            OFS_MTIME_LO:    rd_word = mtime[31:0];
            OFS_MTIME_HI:    rd_word = mtime[63:32];
            OFS_MTIMECMP_LO: rd_word = mtimecmp[31:0];
            OFS_MTIMECMP_HI: rd_word = mtimecmp[63:32];
            OFS_CTRL:        rd_word = ctrl_word;
            default:         rd_word = '0;
        endcase
    end

    assign wr_val = byte_merge(rd_word, wb_dat_mosi, wb_sel);

    wb_timer_counter #(.PRESCALE_W(PRESCALE_W)) u_counter (
        .clk       (clk),
        .rst       (rst),
        .en        (ctrl_en),
        .div       (ctrl_div),
        .load_lo   (wr && (ofs == OFS_MTIME_LO)),
        .load_hi   (wr && (ofs == OFS_MTIME_HI)),
        .load_data (wr_val),
        .clr_pre   (wr && (ofs == OFS_CTRL)),
        .mtime     (mtime)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (wb_cyc && wb_stb) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // termination is dropped if the master abandoned the cycle
    always_comb begin
        wb_ack = (state == RESP) && wb_cyc && hit_q;
        wb_err = (state == RESP) && wb_cyc && !hit_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtimecmp            <= '1;
            ctrl_en             <= 1'b0;
            ctrl_div            <= '0;
            hit_q               <= 1'b0;
            wb_dat_miso         <= '0;
            timer_interrupt_out <= 1'b0;
        end else begin
            timer_interrupt_out <= ctrl_en && (mtime >= mtimecmp);
            if (req) begin
                hit_q       <= hit;
                wb_dat_miso <= (hit && !wb_we) ? rd_word : '0;
            end else begin
                wb_dat_miso <= '0;
            end
            if (wr) begin
                case (ofs)
                    OFS_MTIMECMP_LO: mtimecmp[31:0]  <= wr_val;
                    OFS_MTIMECMP_HI: mtimecmp[63:32] <= wr_val;
                    OFS_CTRL: begin
                        ctrl_en  <= wr_val[CTRL_EN_BIT];
                        ctrl_div <= wr_val[CTRL_DIV_LSB +: PRESCALE_W];
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wb_timer_responder.sv
// Bench for wb_timer_responder: table of bus vectors with a scoreboard,
// plus timed sequences for counting, prescaling, wrap, interrupt and reset.
module tb_wb_timer_responder;

    localparam logic [31:0] B = 32'h0200_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
    logic [3:0]  wb_sel = 4'h0;
    logic [31:0] wb_adr = '0, wb_dat_mosi = '0;
    logic [31:0] wb_dat_miso;
    logic        wb_ack, wb_err, timer_interrupt_out;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_no = 0;
    logic last_irq;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        chk_data;
        logic [31:0] exp_data;
        logic        exp_ack;
        logic        exp_err;
        string       name;
    } vec_t;

    typedef struct {
        logic        chk_data;
        logic [31:0] data;
        logic        ack;
        logic        err;
        string       name;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[$];

    wb_timer_responder #(.BASE_ADDR(B), .PRESCALE_W(16)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .wb_cyc              (wb_cyc),
        .wb_stb              (wb_stb),
        .wb_we               (wb_we),
        .wb_sel              (wb_sel),
        .wb_adr              (wb_adr),
        .wb_dat_mosi         (wb_dat_mosi),
        .wb_dat_miso         (wb_dat_miso),
        .wb_ack              (wb_ack),
        .wb_err              (wb_err),
        .timer_interrupt_out (timer_interrupt_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_no <= edge_no + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                                input logic [3:0] sel, input logic cd, input logic [31:0] ed,
                                input logic ea, input logic ee, input string nm);
        vec_t v;
        v.we = we; v.adr = adr; v.dat = dat; v.sel = sel; v.chk_data = cd;
        v.exp_data = ed; v.exp_ack = ea; v.exp_err = ee; v.name = nm;
        return v;
    endfunction

    function automatic vec_t rd_v(input logic [31:0] adr, input logic [31:0] ed, input string nm);
        return mk(1'b0, adr, 32'h0, 4'hF, 1'b1, ed, 1'b1, 1'b0, nm);
    endfunction

    function automatic vec_t wr_v(input logic [31:0] adr, input logic [31:0] dat,
                                  input logic [3:0] sel, input string nm);
        return mk(1'b1, adr, dat, sel, 1'b0, 32'h0, 1'b1, 1'b0, nm);
    endfunction

    function automatic vec_t er_v(input logic we, input logic [31:0] adr, input string nm);
        return mk(we, adr, 32'h5555_5555, 4'hF, 1'b1, 32'h0, 1'b0, 1'b1, nm);
    endfunction

    // one classic cycle: drive, access edge, sample in the response cycle
    task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, output logic [31:0] rdata,
                        output logic ack, output logic err, output int acc);
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_mosi = dat; wb_sel = sel;
        @(negedge clk);
        acc = edge_no; rdata = wb_dat_miso; ack = wb_ack; err = wb_err;
        last_irq = timer_interrupt_out;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        @(posedge clk);
    endtask

    task automatic access(input vec_t v);
        exp_t e;
        logic [31:0] rd;
        logic a, er;
        int acc;
        e.chk_data = v.chk_data; e.data = v.exp_data; e.ack = v.exp_ack;
        e.err = v.exp_err; e.name = v.name;
        sb.push_back(e);
        xfer(v.we, v.adr, v.dat, v.sel, rd, a, er, acc);
        e = sb.pop_front();
        chk({e.name, "_ack"}, a, e.ack);
        chk({e.name, "_err"}, er, e.err);
        if (e.chk_data) chk({e.name, "_data"}, rd, e.data);
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input string nm);
        access(wr_v(adr, dat, 4'hF, nm));
    endtask

    // wait so that the next xfer's access edge lands at (ref_edge + phase) mod 4
    task automatic align4(input int ref_edge, input int phase);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (((edge_no + 2 - ref_edge) % 4) == phase) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic a, er;
        int e_en, acc, w_ld, c_wr;
        logic [63:0] m, m_c;

        repeat (3) @(negedge clk);
        chk("rst_ack", wb_ack, 1'b0);
        chk("rst_err", wb_err, 1'b0);
        chk("rst_miso", wb_dat_miso, 32'h0);
        chk("rst_irq", timer_interrupt_out, 1'b0);
        rst = 1'b1;

        tbl.push_back(rd_v(B + 32'h10, 32'h0000_0000, "rst_ctrl"));
        tbl.push_back(rd_v(B + 32'h0C, 32'hFFFF_FFFF, "rst_cmp_hi"));
        tbl.push_back(rd_v(B + 32'h08, 32'hFFFF_FFFF, "rst_cmp_lo"));
        tbl.push_back(rd_v(B + 32'h00, 32'h0000_0000, "rst_mtime_lo"));
        tbl.push_back(rd_v(B + 32'h04, 32'h0000_0000, "rst_mtime_hi"));
        tbl.push_back(wr_v(B + 32'h08, 32'hAABB_CCDD, 4'b0101, "wr_sel5"));
        tbl.push_back(rd_v(B + 32'h08, 32'hFFBB_FFDD, "rd_sel5"));
        tbl.push_back(wr_v(B + 32'h08, 32'h1234_5678, 4'b0000, "wr_sel0"));
        tbl.push_back(rd_v(B + 32'h08, 32'hFFBB_FFDD, "rd_sel0"));
        tbl.push_back(er_v(1'b0, B + 32'h14, "err_rd_14"));
        tbl.push_back(er_v(1'b0, B + 32'h1C, "err_rd_1c"));
        tbl.push_back(er_v(1'b0, B + 32'h100, "err_rd_out"));
        tbl.push_back(er_v(1'b1, B + 32'h100, "err_wr_out"));
        tbl.push_back(er_v(1'b1, B + 32'h18, "err_wr_18"));
        tbl.push_back(rd_v(B + 32'h00, 32'h0000_0000, "err_no_write"));
        tbl.push_back(rd_v(B + 32'h08, 32'hFFBB_FFDD, "err_cmp_kept"));
        tbl.push_back(wr_v(B + 32'h10, 32'hFFFF_FFFE, 4'hF, "wr_ctrl_rsvd"));
        tbl.push_back(rd_v(B + 32'h10, 32'hFFFF_0000, "rd_ctrl_rsvd"));
        tbl.push_back(wr_v(B + 32'h10, 32'h0000_0000, 4'hF, "wr_ctrl_0"));
        tbl.push_back(wr_v(B + 32'h0C, 32'h1234_5678, 4'hF, "wr_cmp_hi"));
        tbl.push_back(rd_v(B + 32'h0C, 32'h1234_5678, "rd_cmp_hi"));
        tbl.push_back(wr_v(B + 32'h04, 32'hDEAD_BEEF, 4'b1100, "wr_mt_hi"));
        tbl.push_back(rd_v(B + 32'h04, 32'hDEAD_0000, "rd_mt_hi"));
        tbl.push_back(wr_v(B + 32'h00, 32'h0000_0007, 4'b0001, "wr_mt_lo"));
        tbl.push_back(rd_v(B + 32'h00, 32'h0000_0007, "rd_mt_lo"));
        tbl.push_back(rd_v(B + 32'h13, 32'h0000_0000, "rd_lowbits"));
        foreach (tbl[i]) access(tbl[i]);
        chk("irq_gated_by_en", timer_interrupt_out, 1'b0);

        // master drops cyc during the response: no ack, write still lands
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = B + 32'h0C;
        wb_dat_mosi = 32'h0000_0077; wb_sel = 4'hF;
        @(posedge clk);
        #1 wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        @(negedge clk);
        chk("cyc_drop_ack", wb_ack, 1'b0);
        chk("cyc_drop_err", wb_err, 1'b0);
        xfer(1'b0, B + 32'h0C, 32'h0, 4'hF, rd, a, er, acc);
        chk("cyc_drop_kept", rd, 32'h0000_0077);
        #1 chk("miso_clears", wb_dat_miso, 32'h0);

        // free-running count, interrupt at mtime == 10
        wr(B + 32'h00, 32'h0, "s1_mt_lo");
        wr(B + 32'h04, 32'h0, "s1_mt_hi");
        wr(B + 32'h08, 32'd10, "s1_cmp_lo");
        wr(B + 32'h0C, 32'h0, "s1_cmp_hi");
        xfer(1'b1, B + 32'h10, 32'h0000_0001, 4'hF, rd, a, er, e_en);
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            if (k >= 9) chk($sformatf("s1_irq_k%0d", k), timer_interrupt_out, (k >= 11));
        end
        xfer(1'b0, B + 32'h00, 32'h0, 4'hF, rd, a, er, acc);
        chk("s1_mtime_lo", rd, 32'(acc - 1 - e_en));
        xfer(1'b1, B + 32'h0C, 32'h1, 4'hF, rd, a, er, acc);
        chk("s1_irq_hold", last_irq, 1'b1);
        @(negedge clk);
        chk("s1_irq_drop", timer_interrupt_out, 1'b0);

        // DIV = 3: one tick per 4 cycles
        wr(B + 32'h10, 32'h0, "s2_stop");
        wr(B + 32'h00, 32'h0, "s2_mt_lo");
        wr(B + 32'h04, 32'h0, "s2_mt_hi");
        xfer(1'b1, B + 32'h10, 32'h0003_0001, 4'hF, rd, a, er, e_en);
        repeat (39) @(posedge clk);
        xfer(1'b0, B + 32'h00, 32'h0, 4'hF, rd, a, er, acc);
        chk("s2_div_model", rd, 32'((acc - 1 - e_en) / 4));
        chk("s2_div_ten", rd, 32'd10);
        // load on a tick edge: load wins and the prescaler restarts
        align4(e_en, 0);
        xfer(1'b1, B + 32'h00, 32'd100, 4'hF, rd, a, er, w_ld);
        xfer(1'b0, B + 32'h00, 32'h0, 4'hF, rd, a, er, acc);
        chk("s2_load_wins", rd, 32'd100 + 32'((acc - 1 - w_ld) / 4));
        // CTRL rewrite mid-period restarts the prescaler
        align4(w_ld, 2);
        xfer(1'b1, B + 32'h10, 32'h0003_0001, 4'hF, rd, a, er, c_wr);
        m_c = 64'd100 + 64'((c_wr - w_ld) / 4);
        @(posedge clk);
        xfer(1'b0, B + 32'h00, 32'h0, 4'hF, rd, a, er, acc);
        chk("s2_ctrl_clr", rd, m_c[31:0] + 32'((acc - 1 - c_wr) / 4));

        // 64-bit wrap with interrupt
        wr(B + 32'h10, 32'h0, "s3_stop");
        wr(B + 32'h08, 32'd5, "s3_cmp_lo");
        wr(B + 32'h0C, 32'h0, "s3_cmp_hi");
        wr(B + 32'h04, 32'hFFFF_FFFF, "s3_mt_hi");
        wr(B + 32'h00, 32'hFFFF_FFFE, "s3_mt_lo");
        xfer(1'b1, B + 32'h10, 32'h0000_0001, 4'hF, rd, a, er, e_en);
        chk("s3_irq_e0", last_irq, 1'b0);
        @(negedge clk); chk("s3_irq_e1", timer_interrupt_out, 1'b1);
        @(negedge clk); chk("s3_irq_e2", timer_interrupt_out, 1'b1);
        @(negedge clk); chk("s3_irq_e3", timer_interrupt_out, 1'b0);
        xfer(1'b0, B + 32'h04, 32'h0, 4'hF, rd, a, er, acc);
        m = 64'hFFFF_FFFF_FFFF_FFFE + 64'(acc - 1 - e_en);
        chk("s3_wrap_hi", rd, m[63:32]);
        xfer(1'b0, B + 32'h00, 32'h0, 4'hF, rd, a, er, acc);
        m = 64'hFFFF_FFFF_FFFF_FFFE + 64'(acc - 1 - e_en);
        chk("s3_wrap_lo", rd, m[31:0]);

        // reset during the response cycle loses the ack
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = B + 32'h0C; wb_sel = 4'hF;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("s4_rst_ack", wb_ack, 1'b0);
        chk("s4_rst_miso", wb_dat_miso, 32'h0);
        chk("s4_rst_irq", timer_interrupt_out, 1'b0);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        access(rd_v(B + 32'h10, 32'h0, "s4_ctrl"));
        access(rd_v(B + 32'h08, 32'hFFFF_FFFF, "s4_cmp_lo"));
        access(rd_v(B + 32'h00, 32'h0, "s4_mtime_lo"));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
